// File: rtl/delay_mem_arbiter_if.sv
// Signal bundle for delay_mem_arbiter: realtime port A, host readback port B,
// zero-fill clear engine and the single-read/single-write delay memory port.
interface delay_mem_arbiter_if #(
  parameter int data_width = 16,
  parameter int mem_size   = 16384
);
  localparam int addr_width = $clog2(mem_size);

  logic                  a_read_req;
  logic [addr_width-1:0] a_read_addr;
  logic [data_width-1:0] a_read_data;
  logic                  a_read_valid;
  logic                  a_write_req;
  logic [addr_width-1:0] a_write_addr;
  logic [data_width-1:0] a_write_data;
  logic                  a_write_ack;

  logic                  b_read_req;
  logic [addr_width-1:0] b_read_addr;
  logic [data_width-1:0] b_read_data;
  logic                  b_read_valid;
  logic                  b_busy;

  logic                  clear_req;
  logic [addr_width-1:0] clear_base;
  logic [addr_width:0]   clear_len;
  logic                  clear_busy;
  logic                  clear_done;

  logic [addr_width-1:0] mem_read_addr;
  logic                  mem_read_en;
  logic [data_width-1:0] mem_data_in;
  logic                  mem_write_en;
  logic [addr_width-1:0] mem_write_addr;
  logic [data_width-1:0] mem_write_data;

  // Requesters plus the memory macro
  modport master (
    output a_read_req, a_read_addr, a_write_req, a_write_addr, a_write_data,
           b_read_req, b_read_addr, clear_req, clear_base, clear_len, mem_data_in,
    input  a_read_data, a_read_valid, a_write_ack, b_read_data, b_read_valid, b_busy,
           clear_busy, clear_done, mem_read_addr, mem_read_en,
           mem_write_en, mem_write_addr, mem_write_data
  );

  // The arbiter itself
  modport slave (
    input  a_read_req, a_read_addr, a_write_req, a_write_addr, a_write_data,
           b_read_req, b_read_addr, clear_req, clear_base, clear_len, mem_data_in,
    output a_read_data, a_read_valid, a_write_ack, b_read_data, b_read_valid, b_busy,
           clear_busy, clear_done, mem_read_addr, mem_read_en,
           mem_write_en, mem_write_addr, mem_write_data
  );
endinterface

// File: rtl/delay_mem_arbiter.sv
// Delay-memory port arbiter: A over B on the read port, A over the clear engine on the
// write port. Define DELAY_ARB_STATS_EN to enable the stall/wait statistics counters.
module delay_mem_arbiter #(
  parameter int data_width = 16,
  parameter int mem_size   = 16384
) (
  input  logic                clk,
  input  logic                reset_n,
  delay_mem_arbiter_if.slave  bus,
  output logic [15:0]         clear_stall_count,
  output logic [15:0]         b_wait_count
);
  localparam int addr_width = $clog2(mem_size);
  localparam int cnt_width  = addr_width + 1;
  localparam logic [cnt_width-1:0]  MEM_WORDS = cnt_width'(mem_size);
  localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(mem_size - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} clr_state_e;

  clr_state_e            state, state_nxt;
  logic                  a_rd_go, b_rd_go, a_wr_go;
  logic                  a_rd_vld, b_rd_vld, a_wr_ack;
  logic                  b_pend;
  logic [addr_width-1:0] b_addr;
  logic                  clr_active, clr_wr_go, clr_last, clr_done_r;
  logic [cnt_width-1:0]  clr_cnt, clr_cnt_inc, clr_len, len_clamped;
  logic [addr_width-1:0] clr_ptr, base_mod;
  logic [data_width-1:0] wr_data;

  // ---------------- read port ----------------
  // Reset gating keeps every combinational output at zero while reset_n is low.
  assign a_rd_go = reset_n & bus.a_read_req;
  assign b_rd_go = reset_n & b_pend & ~bus.a_read_req;

  always_comb begin
    bus.mem_read_en   = a_rd_go | b_rd_go;
    bus.mem_read_addr = '0;
    if (a_rd_go)      bus.mem_read_addr = bus.a_read_addr;
    else if (b_rd_go) bus.mem_read_addr = b_addr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rd_vld <= 1'b0;
      b_rd_vld <= 1'b0;
      a_wr_ack <= 1'b0;
      b_pend   <= 1'b0;
      b_addr   <= '0;
    end else begin
      a_rd_vld <= a_rd_go;
      b_rd_vld <= b_rd_go;
      a_wr_ack <= a_wr_go;
      // A request seen while one is pending (including its issue cycle) is dropped.
      if (b_rd_go) begin
        b_pend <= 1'b0;
      end else if (!b_pend && bus.b_read_req) begin
        b_pend <= 1'b1;
        b_addr <= bus.b_read_addr;
      end
    end
  end

  assign bus.a_read_valid = a_rd_vld;
  assign bus.a_read_data  = a_rd_vld ? bus.mem_data_in : '0;
  assign bus.b_read_valid = b_rd_vld;
  assign bus.b_read_data  = b_rd_vld ? bus.mem_data_in : '0;
  assign bus.b_busy       = b_pend;
  assign bus.a_write_ack  = a_wr_ack;

  // ---------------- write port ----------------
  assign a_wr_go = reset_n & bus.a_write_req;
  assign wr_data = a_wr_go ? bus.a_write_data : '0;

  always_comb begin
    bus.mem_write_en   = a_wr_go | clr_wr_go;
    bus.mem_write_data = wr_data;
    bus.mem_write_addr = '0;
    if (a_wr_go)        bus.mem_write_addr = bus.a_write_addr;
    else if (clr_wr_go) bus.mem_write_addr = clr_ptr;
  end

  // ---------------- clear engine ----------------
  generate
    if (mem_size == (1 << addr_width)) begin : g_pow2
      assign base_mod = bus.clear_base;
    end else begin : g_npow2
      assign base_mod = (bus.clear_base > LAST_ADDR) ?
                        bus.clear_base - LAST_ADDR - 1'b1 : bus.clear_base;
    end
  endgenerate

  assign len_clamped = (bus.clear_len > MEM_WORDS) ? MEM_WORDS : bus.clear_len;
  assign clr_cnt_inc = clr_cnt + cnt_width'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.clear_req && bus.clear_len != '0) state_nxt = CLEAR;
      CLEAR:   if (clr_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clr_active     = (state == CLEAR);
    clr_wr_go      = clr_active & ~bus.a_write_req;
    clr_last       = clr_wr_go & (clr_cnt_inc == clr_len);
    bus.clear_busy = clr_active;
    bus.clear_done = clr_done_r;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt    <= '0;
      clr_len    <= '0;
      clr_ptr    <= '0;
      clr_done_r <= 1'b0;
    end else begin
      clr_done_r <= 1'b0;
      if (state == IDLE) begin
        if (bus.clear_req) begin
          if (bus.clear_len == '0) begin
            clr_done_r <= 1'b1;
          end else begin
            clr_cnt <= '0;
            clr_len <= len_clamped;
            clr_ptr <= base_mod;
          end
        end
      end else if (clr_wr_go) begin
        clr_cnt    <= clr_cnt_inc;
        clr_ptr    <= (clr_ptr == LAST_ADDR) ? '0 : clr_ptr + 1'b1;
        clr_done_r <= clr_last;
      end
    end
  end

  // ---------------- statistics ----------------
`ifdef DELAY_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clear_stall_count <= '0;
      b_wait_count      <= '0;
    end else begin
      if (clr_active && bus.a_write_req && clear_stall_count != 16'hFFFF)
        clear_stall_count <= clear_stall_count + 16'd1;
      if (b_pend && bus.a_read_req && b_wait_count != 16'hFFFF)
        b_wait_count <= b_wait_count + 16'd1;
    end
  end
`else
  assign clear_stall_count = '0;
  assign b_wait_count      = '0;
`endif

endmodule
